disp_timing_gen: RTL and testbench

Display timing and line-fetch generator that sits directly downstream of the display-setting sequencer. It consumes `DISPADDR`, `DISPON` and `CLRVBLNK`, and returns the sticky `VBLANK` flag that the sequencer polls. It produces the video syncs and data-enable for the output PHY. It also issues one frame-buffer line-fetch request per active line to the memory reader, which sits downstream.

---
 rtl/disp_timing_gen_pkg.sv | 32 +++
 rtl/disp_timing_gen_if.sv | 27 ++
 rtl/disp_hv_counter.sv | 48 ++++
 rtl/disp_timing_gen.sv | 138 +++++++++++++
 tb/tb_disp_timing_gen.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/disp_timing_gen_pkg.sv
// Shared timing constants, address type and frame-size helpers for the
// display timing generator.
package disp_pkg;

  localparam int ADDR_W = 30;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_LINE_BYTES = 1280;

  typedef logic [ADDR_W-1:0] addr_t;

  function automatic int h_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

  // Counter width able to hold 0..total-1.
  function automatic int cnt_w(int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/disp_timing_gen_if.sv
// Sequencer, PHY and memory-reader facing signals of the timing generator.
interface disp_timing_gen_if;
  import disp_pkg::*;

  addr_t DISPADDR;
  logic  DISPON;
  logic  CLRVBLNK;
  logic  VBLANK;
  logic  HSYNC;
  logic  VSYNC;
  logic  DE;
  logic  FETCH_VALID;
  logic  FETCH_READY;
  addr_t FETCH_ADDR;
  logic  UNDERRUN;

  modport master (
    input  DISPADDR, DISPON, CLRVBLNK, FETCH_READY,
    output VBLANK, HSYNC, VSYNC, DE, FETCH_VALID, FETCH_ADDR, UNDERRUN
  );

  modport slave (
    output DISPADDR, DISPON, CLRVBLNK, FETCH_READY,
    input  VBLANK, HSYNC, VSYNC, DE, FETCH_VALID, FETCH_ADDR, UNDERRUN
  );

endinterface

// File: rtl/disp_hv_counter.sv
// Horizontal/vertical raster counters with vblank-start and fetch-slot strobes
// decoded from the current counter state.
module disp_hv_counter
  import disp_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_TOTAL  = 525,
  parameter int HW       = cnt_w(H_TOTAL),
  parameter int VW       = cnt_w(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          vblank_start_o,
  output logic          fetch_slot_o
);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == HW'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o            = h_q;
  assign v_o            = v_q;
  assign vblank_start_o = (v_q == VW'(V_ACTIVE)) && (h_q == '0);
  assign fetch_slot_o   = (h_q == HW'(H_ACTIVE));

endmodule

// File: rtl/disp_timing_gen.sv
// Display timing generator: syncs, data enable, sticky VBLANK and one
// frame-buffer line-fetch request per active line, all outputs registered.
module disp_timing_gen
  import disp_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int LINE_BYTES = DEF_LINE_BYTES
) (
  input logic               clk,
  input logic               rst,
  disp_timing_gen_if.master bus
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = cnt_w(H_TOTAL);
  localparam int VW      = cnt_w(V_TOTAL);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          vstart, slot;

  disp_hv_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_TOTAL  (H_TOTAL),
    .V_ACTIVE (V_ACTIVE),
    .V_TOTAL  (V_TOTAL),
    .HW       (HW),
    .VW       (VW)
  ) u_hv (
    .clk            (clk),
    .rst            (rst),
    .h_o            (h),
    .v_o            (v),
    .vblank_start_o (vstart),
    .fetch_slot_o   (slot)
  );

  addr_t base_q, base_d, line_q, line_d, faddr_q, faddr_d;
  logic  en_q, en_d, vblank_q, vblank_d;
  logic  hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic  fvalid_q, fvalid_d, urun_q, urun_d;

  logic  tgt_vld;
  addr_t tgt_addr;
  logic  pending;

  // Target line for this slot: last raster line prefetches line 0 from the
  // frame base, active lines prefetch the following line.
  always_comb begin
    tgt_vld  = 1'b0;
    tgt_addr = line_q;
    if (slot) begin
      if (v == VW'(V_TOTAL - 1)) begin
        tgt_vld  = 1'b1;
        tgt_addr = base_q;
      end else if (v < VW'(V_ACTIVE - 1)) begin
        tgt_vld  = 1'b1;
        tgt_addr = line_q + addr_t'(LINE_BYTES);
      end
    end
  end

  assign pending = fvalid_q && !bus.FETCH_READY;

  always_comb begin
    base_d   = base_q;
    en_d     = en_q;
    if (vstart) begin
      base_d = bus.DISPADDR;
      en_d   = bus.DISPON;
    end

    if (bus.CLRVBLNK)  vblank_d = 1'b0;
    else if (vstart)   vblank_d = 1'b1;
    else               vblank_d = vblank_q;

    hsync_d = !((h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC)));
    vsync_d = !((v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC)));
    de_d    = en_q && (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));

    // Line address tracks the raster even when a request is skipped.
    line_d   = tgt_vld ? tgt_addr : line_q;
    fvalid_d = pending;
    faddr_d  = faddr_q;
    urun_d   = urun_q;
    if (tgt_vld && en_q) begin
      if (pending) begin
        urun_d = 1'b1;
      end else begin
        fvalid_d = 1'b1;
        faddr_d  = tgt_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      en_q     <= 1'b0;
      line_q   <= '0;
      vblank_q <= 1'b0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      de_q     <= 1'b0;
      fvalid_q <= 1'b0;
      faddr_q  <= '0;
      urun_q   <= 1'b0;
    end else begin
      base_q   <= base_d;
      en_q     <= en_d;
      line_q   <= line_d;
      vblank_q <= vblank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      fvalid_q <= fvalid_d;
      faddr_q  <= faddr_d;
      urun_q   <= urun_d;
    end
  end

  assign bus.VBLANK      = vblank_q;
  assign bus.HSYNC       = hsync_q;
  assign bus.VSYNC       = vsync_q;
  assign bus.DE          = de_q;
  assign bus.FETCH_VALID = fvalid_q;
  assign bus.FETCH_ADDR  = faddr_q;
  assign bus.UNDERRUN    = urun_q;

endmodule

// File: tb/tb_disp_timing_gen.sv
// Directed and randomized checks of disp_timing_gen against a raster-arithmetic
// reference model on a 14x7 test raster.
module tb_disp_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int LB = 16;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic rst;

  disp_timing_gen_if bus();

  disp_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LINE_BYTES(LB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: raster position is derived from the cycle count since
  // reset; line n of a frame lives at base + n*LB.
  int unsigned cyc;
  logic [29:0] m_base, m_fa;
  logic        m_en, m_vb, m_hs, m_vs, m_de, m_fv, m_ur;

  logic [29:0] fq[$];
  logic        pv;
  logic [29:0] pa;
  int          de_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int h, v;
    bit has, pend;
    logic [29:0] tgt;
    if (rst) begin
      cyc = 0; m_base = '0; m_en = 0; m_vb = 0; m_hs = 1; m_vs = 1;
      m_de = 0; m_fv = 0; m_fa = '0; m_ur = 0;
      return;
    end
    h = int'(cyc % HT);
    v = int'((cyc / HT) % VT);
    m_hs = !(h >= HA + HF && h < HA + HF + HS);
    m_vs = !(v >= VA + VF && v < VA + VF + VS);
    m_de = m_en && h < HA && v < VA;
    if (bus.CLRVBLNK) m_vb = 0;
    else if (v == VA && h == 0) m_vb = 1;
    has = 0;
    tgt = '0;
    if (h == HA) begin
      if (v == VT - 1) begin has = 1; tgt = m_base; end
      else if (v + 1 < VA) begin has = 1; tgt = m_base + 30'((v + 1) * LB); end
    end
    pend = m_fv && !bus.FETCH_READY;
    m_fv = pend;
    if (has && m_en) begin
      if (pend) m_ur = 1;
      else begin m_fv = 1; m_fa = tgt; end
    end
    if (v == VA && h == 0) begin
      m_base = bus.DISPADDR;
      m_en   = bus.DISPON;
    end
    cyc++;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("VBLANK", bus.VBLANK, m_vb);
    chk("HSYNC", bus.HSYNC, m_hs);
    chk("VSYNC", bus.VSYNC, m_vs);
    chk("DE", bus.DE, m_de);
    chk("FETCH_VALID", bus.FETCH_VALID, m_fv);
    chk("FETCH_ADDR", bus.FETCH_ADDR, m_fa);
    chk("UNDERRUN", bus.UNDERRUN, m_ur);
    if (bus.FETCH_VALID && (!pv || bus.FETCH_ADDR != pa)) fq.push_back(bus.FETCH_ADDR);
    pv = bus.FETCH_VALID;
    pa = bus.FETCH_ADDR;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) cycle();
    rst = 0;
    fq.delete();
  endtask

  initial begin
    rst = 1;
    bus.DISPADDR = '0; bus.DISPON = 0; bus.CLRVBLNK = 0; bus.FETCH_READY = 1;
    pv = 0; pa = '0;

    // Reset state, VBLANK timing, fetch sequence and DE over two frames.
    do_reset();
    chk("rst_hsync", bus.HSYNC, 1);
    chk("rst_faddr", bus.FETCH_ADDR, 0);
    bus.DISPADDR = 30'h100; bus.DISPON = 1;
    de_cnt = 0;
    for (int t = 0; t < 196; t++) begin
      cycle();
      if (t == 55) chk("vb_c56", bus.VBLANK, 0);
      if (t == 56) chk("vb_c57", bus.VBLANK, 1);
      if (t == 10) chk("hs_c11", bus.HSYNC, 0);
      if (t >= 97 && t <= 194 && bus.DE) de_cnt++;
    end
    chk("de_frame2", de_cnt, 32);
    chk("nfetch", fq.size(), 5);
    chk("fetch0", fq[0], 30'h100);
    chk("fetch1", fq[1], 30'h110);
    chk("fetch2", fq[2], 30'h120);
    chk("fetch3", fq[3], 30'h130);

    // CLRVBLNK across vblank start suppresses the flag until next frame.
    do_reset();
    bus.DISPON = 0;
    for (int t = 0; t < 160; t++) begin
      bus.CLRVBLNK = (t <= 60);
      cycle();
      if (t == 99) chk("vb_clr_c100", bus.VBLANK, 0);
      if (t == 154) chk("vb_clr_c155", bus.VBLANK, 1);
    end
    bus.CLRVBLNK = 0;

    // Address wrap modulo 2^30.
    do_reset();
    bus.DISPADDR = 30'h3FFFFFF8; bus.DISPON = 1;
    for (int t = 0; t < 125; t++) cycle();
    chk("wrap_n", fq.size() >= 2, 1);
    chk("wrap_l0", fq[0], 30'h3FFFFFF8);
    chk("wrap_l1", fq[1], 30'h00000008);

    // Ready held low across a full line: request held, next line skipped.
    do_reset();
    bus.DISPADDR = 30'h100; bus.DISPON = 1;
    for (int t = 0; t < 200; t++) begin
      bus.FETCH_READY = !(t >= 92 && t <= 106);
      cycle();
      if (t == 104) begin
        chk("hold_valid", bus.FETCH_VALID, 1);
        chk("hold_addr", bus.FETCH_ADDR, 30'h100);
      end
      if (t == 110) chk("urun_set", bus.UNDERRUN, 1);
      if (t == 199) chk("urun_sticky", bus.UNDERRUN, 1);
    end
    chk("skip_next", fq.size() >= 2 ? fq[1] : 30'h0, 30'h120);
    bus.FETCH_READY = 1;

    // Randomized inputs with occasional resets.
    do_reset();
    for (int t = 0; t < 500; t++) begin
      bus.DISPADDR    = 30'($urandom);
      bus.DISPON      = ($urandom_range(0, 3) != 0);
      bus.CLRVBLNK    = ($urandom_range(0, 7) == 0);
      bus.FETCH_READY = ($urandom_range(0, 3) != 0);
      rst             = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 0; bus.CLRVBLNK = 0; bus.FETCH_READY = 1;

    // Reset in the middle of a pending handshake on line 2.
    do_reset();
    bus.DISPADDR = 30'h200; bus.DISPON = 1;
    for (int t = 0; t < 130; t++) begin
      bus.FETCH_READY = (t < 118);
      cycle();
      if (t == 129) chk("mid_pending", bus.FETCH_VALID, 1);
    end
    rst = 1;
    cycle();
    rst = 0;
    chk("mr_valid", bus.FETCH_VALID, 0);
    chk("mr_addr", bus.FETCH_ADDR, 0);
    chk("mr_urun", bus.UNDERRUN, 0);
    chk("mr_vblank", bus.VBLANK, 0);
    chk("mr_hsync", bus.HSYNC, 1);
    chk("mr_vsync", bus.VSYNC, 1);
    chk("mr_de", bus.DE, 0);
    for (int k = 0; k < 14; k++) begin
      cycle();
      if (k == 10) chk("mr_restart_hs", bus.HSYNC, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
